// File: rtl/pce_audio_mixer_tdm_pkg.sv
// Shared constants, compressor mode encoding and arithmetic helpers for the
// time-multiplexed PCE audio mixer.
package pce_audio_pkg;

  localparam int GAIN_FRAC = 6;

  typedef enum logic [1:0] {
    CM_OFF     = 2'd0,
    CM_MILD    = 2'd1,
    CM_STRONG  = 2'd2,
    CM_OFF_ALT = 2'd3
  } comp_mode_t;

  // Knee of a two-slope curve with gain a below the knee and 1/f above,
  // chosen so that full scale maps back near full scale.
  function automatic int comp_knee(input int f, input int a, input int out_w);
    int m;
    m = (1 << (out_w - 1)) - 1;
    return m * (f - 1) / (f * a - 1) + 1;
  endfunction

  function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v, input int w);
    logic signed [63:0] m;
    m = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

endpackage

// File: rtl/pce_audio_mixer_tdm_if.sv
// Source/control bundle and mixed-output bundle of the TDM audio mixer.
interface pce_audio_mixer_tdm_if #(
  parameter int NUM_CH = 5,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 8
);
  logic                       sample_ce;
  logic [NUM_CH*IN_W-1:0]     ch_in_l;
  logic [NUM_CH*IN_W-1:0]     ch_in_r;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain;
  logic [NUM_CH-1:0]          ch_en;
  logic [1:0]                 comp_mode;
  logic                       clip_clr;
  logic signed [OUT_W-1:0]    audio_l;
  logic signed [OUT_W-1:0]    audio_r;
  logic                       out_valid;
  logic                       busy;
  logic                       clip_l;
  logic                       clip_r;
  logic                       overrun;

  modport master (
    output sample_ce, ch_in_l, ch_in_r, ch_gain, ch_en, comp_mode, clip_clr,
    input  audio_l, audio_r, out_valid, busy, clip_l, clip_r, overrun
  );

  modport slave (
    input  sample_ce, ch_in_l, ch_in_r, ch_gain, ch_en, comp_mode, clip_clr,
    output audio_l, audio_r, out_valid, busy, clip_l, clip_r, overrun
  );
endinterface

// File: rtl/pce_audio_mixer_tdm_compressor.sv
// Registered two-slope magnitude compressor; the register doubles as the
// held audio output of one mixer side.
module pce_audio_compressor
  import pce_audio_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  comp_mode_t              mode,
  input  logic signed [OUT_W-1:0] din,
  output logic signed [OUT_W-1:0] dout_q
);
  localparam int CW = OUT_W + 4;
  localparam int X_MILD   = comp_knee(4, 2, OUT_W);
  localparam int X_STRONG = comp_knee(8, 4, OUT_W);
  localparam logic [CW-1:0] MAXV = CW'((64'd1 << (OUT_W - 1)) - 64'd1);

  function automatic logic [CW-1:0] curve(input logic [CW-1:0] m, input int x, input int f,
                                          input int a);
    if (m < CW'(x)) return m * CW'(a);
    return (m - CW'(x)) / CW'(f) + CW'(x) * CW'(a);
  endfunction

  logic [OUT_W-1:0]        abs_v;
  logic [CW-1:0]           mag;
  logic [CW-1:0]           res;
  logic signed [OUT_W-1:0] dout_d;

  // Input never holds the most negative code, so its magnitude fits OUT_W bits.
  always_comb begin
    abs_v = din[OUT_W-1] ? OUT_W'(-din) : OUT_W'(din);
    mag   = CW'(abs_v);
    case (mode)
      CM_MILD:   res = curve(mag, X_MILD, 4, 2);
      CM_STRONG: res = curve(mag, X_STRONG, 8, 4);
      default:   res = mag;
    endcase
    if (res > MAXV) res = MAXV;
    dout_d = dout_q;
    if (en) dout_d = din[OUT_W-1] ? -$signed(OUT_W'(res)) : $signed(OUT_W'(res));
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end
endmodule

// File: rtl/pce_audio_mixer_tdm.sv
// N-channel stereo mixer: one channel MAC per cycle with ramped gains,
// symmetric saturation, then a selectable compressor per side.
module pce_audio_mixer_tdm
  import pce_audio_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 1
) (
  input logic                  clk_sys_42_95,
  input logic                  reset,
  pce_audio_mixer_tdm_if.slave bus
);
  localparam int ACC_W  = IN_W + GAIN_W + 1 + $clog2(NUM_CH + 1);
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_ACC, ST_SAT, ST_CMP, ST_OUT} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_CH*IN_W-1:0]   in_l_q, in_l_d, in_r_q, in_r_d;
  logic [NUM_CH-1:0]        en_q, en_d;
  comp_mode_t               mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0]  sat_l_q, sat_l_d, sat_r_q, sat_r_d;
  logic [GAIN_W-1:0]        gain_q [NUM_CH];
  logic [GAIN_W-1:0]        gain_d [NUM_CH];
  logic                     clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic                     ovr_q, ovr_d, vld_q, vld_d;
  logic                     cmp_en;
  logic signed [IN_W-1:0]   smp_l, smp_r;
  logic signed [PROD_W-1:0] prod_l, prod_r, gain_s;
  logic signed [ACC_W-1:0]  shr_l, shr_r;
  logic signed [63:0]       lim_l, lim_r;
  logic signed [OUT_W-1:0]  cmp_l, cmp_r;

  function automatic logic [GAIN_W-1:0] ramp(input logic [GAIN_W-1:0] cur,
                                             input logic [GAIN_W-1:0] tgt);
    logic [GAIN_W-1:0] step;
    step = GAIN_W'(RAMP_STEP);
    if (RAMP_STEP == 0) return tgt;
    if (cur < tgt) return (tgt - cur > step) ? cur + step : tgt;
    if (cur > tgt) return (cur - tgt > step) ? cur - step : tgt;
    return cur;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    in_l_d   = in_l_q;
    in_r_d   = in_r_q;
    en_d     = en_q;
    mode_d   = mode_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    sat_l_d  = sat_l_q;
    sat_r_d  = sat_r_q;
    gain_d   = gain_q;
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    ovr_d    = ovr_q;
    vld_d    = 1'b0;
    cmp_en   = 1'b0;

    smp_l  = $signed(in_l_q[idx_q*IN_W +: IN_W]);
    smp_r  = $signed(in_r_q[idx_q*IN_W +: IN_W]);
    gain_s = PROD_W'($signed({1'b0, gain_q[idx_q]}));
    prod_l = PROD_W'(smp_l) * gain_s;
    prod_r = PROD_W'(smp_r) * gain_s;
    shr_l  = acc_l_q >>> GAIN_FRAC;
    shr_r  = acc_r_q >>> GAIN_FRAC;
    lim_l  = sat_sym(64'(shr_l), OUT_W);
    lim_r  = sat_sym(64'(shr_r), OUT_W);

    // Clear first so a flag raised in the same cycle survives the clear.
    if (bus.clip_clr) begin
      clip_l_d = 1'b0;
      clip_r_d = 1'b0;
      ovr_d    = 1'b0;
    end
    if (bus.sample_ce && state_q != ST_IDLE) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.sample_ce) begin
          in_l_d  = bus.ch_in_l;
          in_r_d  = bus.ch_in_r;
          en_d    = bus.ch_en;
          mode_d  = comp_mode_t'(bus.comp_mode);
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (en_q[idx_q]) begin
          acc_l_d = acc_l_q + ACC_W'(prod_l);
          acc_r_d = acc_r_q + ACC_W'(prod_r);
        end
        // Disabled channels still ramp so re-enabling lands on schedule.
        gain_d[idx_q] = ramp(gain_q[idx_q], bus.ch_gain[idx_q*GAIN_W +: GAIN_W]);
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = ST_SAT;
        else                             idx_d   = idx_q + IDX_W'(1);
      end
      ST_SAT: begin
        sat_l_d = OUT_W'(lim_l);
        sat_r_d = OUT_W'(lim_r);
        if (lim_l != 64'(shr_l)) clip_l_d = 1'b1;
        if (lim_r != 64'(shr_r)) clip_r_d = 1'b1;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        cmp_en  = 1'b1;
        vld_d   = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_42_95) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      in_l_q   <= '0;
      in_r_q   <= '0;
      en_q     <= '0;
      mode_q   <= CM_OFF;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      sat_l_q  <= '0;
      sat_r_q  <= '0;
      gain_q   <= '{default: '0};
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      ovr_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      in_l_q   <= in_l_d;
      in_r_q   <= in_r_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      sat_l_q  <= sat_l_d;
      sat_r_q  <= sat_r_d;
      gain_q   <= gain_d;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      ovr_q    <= ovr_d;
      vld_q    <= vld_d;
    end
  end

  pce_audio_compressor #(.OUT_W(OUT_W)) u_cmp_l (
    .clk(clk_sys_42_95), .rst(reset), .en(cmp_en), .mode(mode_q), .din(sat_l_q), .dout_q(cmp_l)
  );
  pce_audio_compressor #(.OUT_W(OUT_W)) u_cmp_r (
    .clk(clk_sys_42_95), .rst(reset), .en(cmp_en), .mode(mode_q), .din(sat_r_q), .dout_q(cmp_r)
  );

  assign bus.audio_l   = cmp_l;
  assign bus.audio_r   = cmp_r;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.clip_l    = clip_l_q;
  assign bus.clip_r    = clip_r_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_pce_audio_mixer_tdm.sv
// Directed bench for the TDM audio mixer: gain ramp, saturation, compressor
// curves, overrun, mid-frame reset and an instant-gain (RAMP_STEP=0) instance.
module tb_pce_audio_mixer_tdm;
  localparam int NC = 5;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pce_audio_mixer_tdm_if #(.NUM_CH(NC), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)) m1 ();
  pce_audio_mixer_tdm_if #(.NUM_CH(NC), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)) m2 ();

  pce_audio_mixer_tdm #(.NUM_CH(NC), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW), .RAMP_STEP(1)) dut (
    .clk_sys_42_95(clk), .reset(rst), .bus(m1.slave)
  );
  pce_audio_mixer_tdm #(.NUM_CH(NC), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW), .RAMP_STEP(0)) dut_jump (
    .clk_sys_42_95(clk), .reset(rst), .bus(m2.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch1(input int i, input int l, input int r, input int g);
    m1.ch_in_l[i*IW +: IW] = IW'(l);
    m1.ch_in_r[i*IW +: IW] = IW'(r);
    m1.ch_gain[i*GW +: GW] = GW'(g);
  endtask

  task automatic run_frame1(output int lat);
    @(posedge clk); #1 m1.sample_ce = 1'b1;
    @(posedge clk); #1 m1.sample_ce = 1'b0;
    lat = 1;
    while (m1.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (m1.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic run_frame2(output int lat);
    @(posedge clk); #1 m2.sample_ce = 1'b1;
    @(posedge clk); #1 m2.sample_ce = 1'b0;
    lat = 1;
    while (m2.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (m2.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic pulse_clr1();
    @(posedge clk); #1 m1.clip_clr = 1'b1;
    @(posedge clk); #1 m1.clip_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int g;
    int cnt;
    m1.sample_ce = 1'b0; m1.clip_clr = 1'b0; m1.comp_mode = 2'd0;
    m1.ch_in_l = '0; m1.ch_in_r = '0; m1.ch_gain = '0; m1.ch_en = '0;
    m2.sample_ce = 1'b0; m2.clip_clr = 1'b0; m2.comp_mode = 2'd0;
    m2.ch_in_l = '0; m2.ch_in_r = '0; m2.ch_gain = '0; m2.ch_en = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_audio_l", $signed(m1.audio_l), 0);
    check_eq("rst_audio_r", $signed(m1.audio_r), 0);
    check_eq("rst_out_valid", m1.out_valid, 0);
    check_eq("rst_busy", m1.busy, 0);
    check_eq("rst_clip_l", m1.clip_l, 0);
    check_eq("rst_clip_r", m1.clip_r, 0);
    check_eq("rst_overrun", m1.overrun, 0);

    // Fade-in from reset: frame k uses gain k-1, capped at unity.
    set_ch1(0, 1000, -1000, 64);
    for (int i = 1; i < NC; i++) set_ch1(i, 0, 0, 64);
    m1.ch_en = 5'b00001;
    for (int k = 1; k <= 70; k++) begin
      run_frame1(lat);
      g = (k - 1 > 64) ? 64 : k - 1;
      check_eq("ramp_latency", lat, 8);
      check_eq("ramp_l", $signed(m1.audio_l), (1000 * g) >>> 6);
      check_eq("ramp_r", $signed(m1.audio_r), (-1000 * g) >>> 6);
      if (k == 2) check_eq("ramp_l_frame2", $signed(m1.audio_l), 15);
      if (k == 3) check_eq("ramp_l_frame3", $signed(m1.audio_l), 31);
      if (k == 2) check_eq("ramp_r_frame2", $signed(m1.audio_r), -16);
      if (k == 65) check_eq("ramp_l_frame65", $signed(m1.audio_l), 1000);
    end
    @(posedge clk); #1;
    check_eq("out_valid_pulse_width", m1.out_valid, 0);
    check_eq("busy_after_frame", m1.busy, 0);

    for (int i = 0; i < NC; i++) set_ch1(i, 20000, -20000, 64);
    m1.ch_en = 5'b11111;
    run_frame1(lat);
    check_eq("sat_latency", lat, 8);
    check_eq("sat_pos_l", $signed(m1.audio_l), 32767);
    check_eq("sat_neg_r", $signed(m1.audio_r), -32767);
    check_eq("clip_l_set", m1.clip_l, 1);
    check_eq("clip_r_set", m1.clip_r, 1);
    pulse_clr1();
    check_eq("clip_l_cleared", m1.clip_l, 0);
    check_eq("clip_r_cleared", m1.clip_r, 0);

    m1.ch_en = 5'b00001;
    m1.comp_mode = 2'd1;
    set_ch1(0, 10000, -20000, 64);
    run_frame1(lat);
    check_eq("mild_10000", $signed(m1.audio_l), 20000);
    check_eq("mild_neg20000", $signed(m1.audio_r), -29577);
    set_ch1(0, 20000, 0, 64);
    run_frame1(lat);
    check_eq("mild_20000", $signed(m1.audio_l), 29577);
    check_eq("mild_zero", $signed(m1.audio_r), 0);

    m1.comp_mode = 2'd2;
    set_ch1(0, 32767, 5000, 64);
    run_frame1(lat);
    check_eq("strong_full_scale", $signed(m1.audio_l), 32767);
    check_eq("strong_5000", $signed(m1.audio_r), 20000);
    check_eq("strong_no_clip", m1.clip_l, 0);

    m1.comp_mode = 2'd3;
    set_ch1(0, 12345, -32768, 64);
    run_frame1(lat);
    check_eq("mode3_bypass", $signed(m1.audio_l), 12345);
    check_eq("min_code_clamped", $signed(m1.audio_r), -32767);
    check_eq("min_code_clip_r", m1.clip_r, 1);
    check_eq("min_code_clip_l", m1.clip_l, 0);
    pulse_clr1();

    // Second strobe three cycles into a frame must be dropped and flagged.
    cnt = 0;
    @(posedge clk); #1 m1.sample_ce = 1'b1;
    @(posedge clk); #1 m1.sample_ce = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 m1.sample_ce = 1'b1;
    @(posedge clk); #1 m1.sample_ce = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (m1.out_valid === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    check_eq("overrun_frames", cnt, 1);
    check_eq("overrun_flag", m1.overrun, 1);
    pulse_clr1();
    check_eq("overrun_cleared", m1.overrun, 0);

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m1.comp_mode = 2'd0;
    set_ch1(0, 1000, -1000, 64);
    m1.ch_en = 5'b00000;
    for (int k = 1; k <= 10; k++) begin
      run_frame1(lat);
      check_eq("disabled_l", $signed(m1.audio_l), 0);
    end
    m1.ch_en = 5'b00001;
    run_frame1(lat);
    check_eq("reenable_l", $signed(m1.audio_l), 156);
    check_eq("reenable_r", $signed(m1.audio_r), -157);

    cnt = 0;
    @(posedge clk); #1 m1.sample_ce = 1'b1;
    @(posedge clk); #1 m1.sample_ce = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_eq("abort_busy", m1.busy, 0);
    check_eq("abort_audio_l", $signed(m1.audio_l), 0);
    check_eq("abort_audio_r", $signed(m1.audio_r), 0);
    for (int j = 0; j < 15; j++) begin
      if (m1.out_valid === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_valid", cnt, 0);

    m2.ch_in_l[0 +: IW] = 16'sd1000;
    m2.ch_gain[0 +: GW] = 8'd64;
    m2.ch_en = 5'b00001;
    run_frame2(lat);
    check_eq("jump_latency", lat, 8);
    check_eq("jump_frame1", $signed(m2.audio_l), 0);
    run_frame2(lat);
    check_eq("jump_frame2", $signed(m2.audio_l), 1000);
    m2.ch_gain[0 +: GW] = 8'd32;
    run_frame2(lat);
    check_eq("jump_frame3", $signed(m2.audio_l), 1000);
    run_frame2(lat);
    check_eq("jump_frame4", $signed(m2.audio_l), 500);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
